rom_port_arbiter: RTL

- Shares one single-port, read-only block RAM (registered read data, 1-cycle latency) between NUM_REQ independent read requesters.
- Typical users are the character-generator pixel fetch path and the APB readback path.
- Each cycle the block grants at most one request, drives the RAM address, and returns the read data to the granted requester exactly one cycle later.
- Arbitration is round-robin, or fixed priority when selected by parameter.

---
 rtl/rom_port_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Arbitrates NUM_REQ read requesters onto one single-port ROM with a 1-cycle registered read.
// The grant is combinational, and the response strobe is a registered copy of that grant.
module rom_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a request k completes in the cycle where req_valid_i[k] and req_ready_o[k]
  // are both 1. The data comes back on rsp_data_o in the next cycle, strobed by
  // rsp_valid_o[k], and the requester cannot apply backpressure to it.

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          win_found;

  // The scan order starts at rr_ptr and wraps. Fixed priority always starts at index 0.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (FIXED_PRIO != 0) cand = IW'(i);
      else                 cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    mem_addr_o  = '0;
    if (win_found) begin
      req_ready_o[win_idx] = 1'b1;
      mem_addr_o           = req_addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The RAM output register already provides the one-cycle latency, so the data passes straight through.
  assign rsp_data_o = mem_rdata_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rr_ptr      <= '0;
      rsp_valid_o <= '0;
    end else begin
      rsp_valid_o <= req_ready_o;
      if (win_found)
        rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

endmodule
